// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: execute-stage multiply/divide sequencer.
// Owns the architectural HI/LO registers. It captures the 64-bit result of a
// mult/div at issue time and holds it as a pending value. The result is
// committed to HI/LO only when the busy countdown finishes, so HI/LO keep
// their old values while the operation is in flight.
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Src_A,
    input  logic [31:0] Src_B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic [31:0]    pend_hi_q, pend_hi_d;
    logic [31:0]    pend_lo_q, pend_lo_d;
    logic           pend_dz_q, pend_dz_d;

    logic signed [63:0] smul_s;
    logic [63:0]        umul_s;
    logic signed [32:0] sdvd_s, sdvs_s, squo_s, srem_s;
    logic [31:0]        udvs_s, uquo_s, urem_s;
    logic               dz_s;

    // Arithmetic datapath. The signed divide is done at 33 bits so that
    // -2^31 / -1 wraps deterministically. A zero divisor is swapped for 1
    // only to keep the datapath X-free; that result is never committed.
    always_comb begin
        dz_s   = (Src_B == 32'd0);
        smul_s = $signed({{32{Src_A[31]}}, Src_A}) * $signed({{32{Src_B[31]}}, Src_B});
        umul_s = {32'd0, Src_A} * {32'd0, Src_B};
        sdvd_s = $signed({Src_A[31], Src_A});
        if (dz_s) begin
            sdvs_s = 33'sd1;
            udvs_s = 32'd1;
        end else begin
            sdvs_s = $signed({Src_B[31], Src_B});
            udvs_s = Src_B;
        end
        squo_s = sdvd_s / sdvs_s;
        srem_s = sdvd_s % sdvs_s;
        uquo_s = Src_A / udvs_s;
        urem_s = Src_A % udvs_s;
    end

    // Next-state logic: issue in IDLE, count down in BUSY, commit on the last cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDUOp)
                        OP_MULT: begin
                            pend_hi_d = smul_s[63:32];
                            pend_lo_d = smul_s[31:0];
                            pend_dz_d = 1'b0;
                            cnt_d     = MULT_CNT;
                            state_d   = BUSY;
                        end
                        OP_MULTU: begin
                            pend_hi_d = umul_s[63:32];
                            pend_lo_d = umul_s[31:0];
                            pend_dz_d = 1'b0;
                            cnt_d     = MULT_CNT;
                            state_d   = BUSY;
                        end
                        OP_DIV: begin
                            pend_hi_d = srem_s[31:0];
                            pend_lo_d = squo_s[31:0];
                            pend_dz_d = dz_s;
                            cnt_d     = DIV_CNT;
                            state_d   = BUSY;
                        end
                        OP_DIVU: begin
                            pend_hi_d = urem_s;
                            pend_lo_d = uquo_s;
                            pend_dz_d = dz_s;
                            cnt_d     = DIV_CNT;
                            state_d   = BUSY;
                        end
                        OP_MTHI: begin
                            hi_d = Src_A;
                        end
                        OP_MTLO: begin
                            lo_d = Src_A;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Any issue attempt while busy is ignored.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State register with synchronous active-high reset; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // mfhi/mflo read mux. It is purely combinational and independent of busy.
    always_comb begin
        case (MDUOp)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            default: MDUOut = 32'd0;
        endcase
    end

endmodule
